// File: rtl/txrx_finish_tracker_ble.sv
// Per-channel TX/RX finish status for the BLE PHY: gap-tolerant end-of-stream detection,
// a no-data watchdog and saturating sample counters. Optional sticky IRQ via FINISH_TRACKER_IRQ_EN.
module txrx_finish_tracker_ble #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 12,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       we,
    input  logic [NUM_CH-1:0]       valid_out,
    output logic [NUM_CH-1:0]       finished,
    output logic [NUM_CH-1:0]       done_pulse,
    output logic [NUM_CH-1:0]       timeout_pulse,
    output logic [NUM_CH*CNT_W-1:0] sample_cnt
`ifdef FINISH_TRACKER_IRQ_EN
    ,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH-1:0]       irq
`endif
);

    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state_q, state_d;
        logic               fin_q, fin_d;
        logic               done_q, done_d;
        logic               to_q, to_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [WD_W-1:0]    wd_q, wd_d;
        logic [GAP_W-1:0]   gap_q, gap_d;

        // Channel state and registered outputs
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                fin_q   <= 1'b1;
                done_q  <= 1'b0;
                to_q    <= 1'b0;
                cnt_q   <= '0;
                wd_q    <= '0;
                gap_q   <= '0;
            end else begin
                state_q <= state_d;
                fin_q   <= fin_d;
                done_q  <= done_d;
                to_q    <= to_d;
                cnt_q   <= cnt_d;
                wd_q    <= wd_d;
                gap_q   <= gap_d;
            end
        end

        // Next-state: a we request always wins over valid_out and abandons the current operation silently
        always_comb begin
            state_d = state_q;
            fin_d   = fin_q;
            done_d  = 1'b0;
            to_d    = 1'b0;
            cnt_d   = cnt_q;
            wd_d    = wd_q;
            gap_d   = gap_q;
            case (state_q)
                S_IDLE: begin
                    if (we[i]) begin
                        state_d = S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (!we[i]) begin
                        state_d = S_WAIT;
                        fin_d   = 1'b0;
                        cnt_d   = '0;
                        wd_d    = '0;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_WAIT: begin
                    if (we[i]) begin
                        state_d = S_ARMED;
                    end else if (valid_out[i]) begin
                        state_d = S_STREAM;
                        cnt_d   = CNT_W'(1);
                        gap_d   = '0;
                    end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                        to_d    = 1'b1;
                    end else if (TIMEOUT_CYC != 0) begin
                        wd_d = wd_q + WD_W'(1);
                    end else begin
                        wd_d = wd_q;
                    end
                end
                S_STREAM: begin
                    if (we[i]) begin
                        state_d = S_ARMED;
                    end else if (valid_out[i]) begin
                        gap_d = '0;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end
            endcase
        end

        assign finished[i]                  = fin_q;
        assign done_pulse[i]                = done_q;
        assign timeout_pulse[i]             = to_q;
        assign sample_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

`ifdef FINISH_TRACKER_IRQ_EN
    logic [NUM_CH-1:0] irq_q, irq_d;

    // Sticky interrupt: a pulse in the same cycle as a clear keeps the bit set
    always_comb begin
        irq_d = (irq_q & ~irq_clr) | done_pulse | timeout_pulse;
    end

    // Interrupt register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
